// File: rtl/mgt_01_alu_arbiter_if.sv
// mgt_01_alu_arbiter_if: request, ALU and writeback signals of the shared-ALU arbiter
interface mgt_01_alu_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int OPS_W  = 5,
  parameter int TAG_W  = 4
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*DATA_W-1:0] req_op_A_i;
  logic [N_REQ*DATA_W-1:0] req_op_B_i;
  logic [N_REQ*OPS_W-1:0]  req_ops_i;
  logic [N_REQ*TAG_W-1:0]  req_tag_i;
  logic [DATA_W-1:0]       alu_op_A_o;
  logic [DATA_W-1:0]       alu_op_B_o;
  logic [OPS_W-1:0]        alu_ops_o;
  logic [DATA_W-1:0]       alu_result_i;
  logic                    alu_comparison_i;
  logic                    alu_fu_state_i;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic [DATA_W-1:0]       res_data_o;
  logic                    res_cmp_o;
  logic [TAG_W-1:0]        res_tag_o;
  logic [1:0]              res_src_o;
  logic                    busy_o;
  modport master (
    input  req_valid_i, req_op_A_i, req_op_B_i, req_ops_i, req_tag_i,
    input  alu_result_i, alu_comparison_i, alu_fu_state_i, res_ready_i,
    output req_ready_o, alu_op_A_o, alu_op_B_o, alu_ops_o,
    output res_valid_o, res_data_o, res_cmp_o, res_tag_o, res_src_o, busy_o
  );
  modport slave (
    output req_valid_i, req_op_A_i, req_op_B_i, req_ops_i, req_tag_i,
    output alu_result_i, alu_comparison_i, alu_fu_state_i, res_ready_i,
    input  req_ready_o, alu_op_A_o, alu_op_B_o, alu_ops_o,
    input  res_valid_o, res_data_o, res_cmp_o, res_tag_o, res_src_o, busy_o
  );
endinterface

// File: rtl/mgt_01_alu_arbiter.sv
// mgt_01_alu_arbiter: round-robin sharing of one integer ALU between N_REQ requesters,
// with the result returned to writeback over a valid/ready port.
module mgt_01_alu_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int OPS_W  = 5,
  parameter int TAG_W  = 4
) (
  input logic clk_i,
  input logic rst_i,
  mgt_01_alu_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0]        ptr_q, win, src_q, res_src_q;
  logic [2:0]        cand;
  logic [3:0]        vld;
  logic              hit, grant_en, grant, done, accept;
  logic [DATA_W-1:0] op_a_q, op_b_q, res_data_q;
  logic [OPS_W-1:0]  ops_q;
  logic [TAG_W-1:0]  tag_q, res_tag_q;
  logic              res_valid_q, res_cmp_q;
  assign vld      = 4'(bus.req_valid_i);
  assign accept   = state_q == RESP && bus.res_ready_i;
  // Grants are suppressed while reset is held so req_ready_o reads zero.
  assign grant_en = !rst_i && (state_q == IDLE || accept);
  assign grant    = grant_en && hit;
  assign done     = state_q == EXEC && bus.alu_fu_state_i;
  always_comb begin
    win  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + 3'(i);
      cand = cand >= 3'(N_REQ) ? cand - 3'(N_REQ) : cand;
      if (vld[cand[1:0]]) begin
        win = cand[1:0];
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = grant ? EXEC : done ? RESP : accept ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ops_q       <= '0;
      tag_q       <= '0;
      src_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmp_q   <= 1'b0;
      res_tag_q   <= '0;
      res_src_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_a_q <= bus.req_op_A_i[int'(win)*DATA_W +: DATA_W];
        op_b_q <= bus.req_op_B_i[int'(win)*DATA_W +: DATA_W];
        ops_q  <= bus.req_ops_i[int'(win)*OPS_W +: OPS_W];
        tag_q  <= bus.req_tag_i[int'(win)*TAG_W +: TAG_W];
        src_q  <= win;
        ptr_q  <= win == 2'(N_REQ - 1) ? 2'd0 : win + 2'd1;
      end
      if (done) begin
        res_data_q <= bus.alu_result_i;
        res_cmp_q  <= bus.alu_comparison_i;
        res_tag_q  <= tag_q;
        res_src_q  <= src_q;
      end
      res_valid_q <= done ? 1'b1 : accept ? 1'b0 : res_valid_q;
    end
  end
  assign bus.req_ready_o = grant ? N_REQ'(1) << win : '0;
  assign bus.alu_op_A_o  = op_a_q;
  assign bus.alu_op_B_o  = op_b_q;
  assign bus.alu_ops_o   = ops_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_cmp_o   = res_cmp_q;
  assign bus.res_tag_o   = res_tag_q;
  assign bus.res_src_o   = res_src_q;
  assign bus.busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_mgt_01_alu_arbiter.sv
// tb_mgt_01_alu_arbiter: directed scenarios against a stand-in ALU with hand-computed results
module tb_mgt_01_alu_arbiter;
  localparam int N = 2, DW = 32, OW = 5, TW = 4;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, EQ = 5'd2, GE = 5'd3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fu  = 1'b1;
  int checks = 0;
  int errors = 0;
  mgt_01_alu_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OPS_W(OW), .TAG_W(TW)) bus ();
  mgt_01_alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OPS_W(OW), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.alu_fu_state_i   = fu;
  assign bus.alu_result_i     = bus.alu_ops_o == ADD ? bus.alu_op_A_o + bus.alu_op_B_o :
                                bus.alu_ops_o == SUB ? bus.alu_op_A_o - bus.alu_op_B_o : '0;
  assign bus.alu_comparison_i = bus.alu_ops_o == EQ ? bus.alu_op_A_o == bus.alu_op_B_o :
                                bus.alu_ops_o == GE ? $signed(bus.alu_op_A_o) >= $signed(bus.alu_op_B_o) : 1'b0;

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [3:0] tag);
    bus.req_op_A_i[k*DW +: DW] = a;
    bus.req_op_B_i[k*DW +: DW] = b;
    bus.req_ops_i[k*OW +: OW]  = op;
    bus.req_tag_i[k*TW +: TW]  = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fu = 1'b1;
    bus.req_valid_i = '0;
    bus.res_ready_i = 1'b0;
    bus.req_op_A_i = '0;
    bus.req_op_B_i = '0;
    bus.req_ops_i = '0;
    bus.req_tag_i = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 7, 9, SUB, 5);
    set_req(1, 1, 2, ADD, 6);
    bus.req_valid_i = 2'b11;
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", bus.req_ready_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_busy_valid got %b%b exp 00", bus.busy_o, bus.res_valid_o); end
    checks++; if ({bus.alu_op_A_o, bus.alu_op_B_o, bus.alu_ops_o} !== '0) begin errors++; $display("FAIL reset_alu got %h %h %h exp 0", bus.alu_op_A_o, bus.alu_op_B_o, bus.alu_ops_o); end
    checks++; if ({bus.res_data_o, bus.res_cmp_o, bus.res_tag_o, bus.res_src_o} !== '0) begin errors++; $display("FAIL reset_res got %h %b %h %h exp 0", bus.res_data_o, bus.res_cmp_o, bus.res_tag_o, bus.res_src_o); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 100, 200, ADD, 3);
    bus.req_valid_i = 2'b01;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    checks++; if (bus.busy_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL single_exec got busy %b valid %b exp 1 0", bus.busy_o, bus.res_valid_o); end
    checks++; if (bus.alu_op_A_o !== 32'd100 || bus.alu_op_B_o !== 32'd200 || bus.alu_ops_o !== ADD) begin errors++; $display("FAIL single_alu got %0d %0d %0d exp 100 200 0", bus.alu_op_A_o, bus.alu_op_B_o, bus.alu_ops_o); end
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd300) begin errors++; $display("FAIL single_result got valid %b data %0d exp 1 300", bus.res_valid_o, bus.res_data_o); end
    checks++; if (bus.res_tag_o !== 4'd3 || bus.res_src_o !== 2'd0) begin errors++; $display("FAIL single_tag_src got %0d %0d exp 3 0", bus.res_tag_o, bus.res_src_o); end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_drain got valid %b busy %b exp 0 0", bus.res_valid_o, bus.busy_o); end
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 500, 200, SUB, 1);
    set_req(1, 200, 200, EQ, 2);
    bus.req_valid_i = 2'b11;
    bus.res_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL cont_first got %b exp 01", bus.req_ready_o); end
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL cont_exec_ready got %b exp 00", bus.req_ready_o); end
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd300 || bus.res_src_o !== 2'd0 || bus.res_tag_o !== 4'd1) begin errors++; $display("FAIL cont_res0 got v%b %0d src %0d tag %0d exp v1 300 src 0 tag 1", bus.res_valid_o, bus.res_data_o, bus.res_src_o, bus.res_tag_o); end
    checks++; if (bus.req_ready_o !== 2'b10) begin errors++; $display("FAIL cont_second got %b exp 10", bus.req_ready_o); end
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL cont_b2b got valid %b busy %b exp 0 1", bus.res_valid_o, bus.busy_o); end
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd0 || bus.res_cmp_o !== 1'b1) begin errors++; $display("FAIL cont_res1 got v%b %0d cmp %b exp v1 0 cmp 1", bus.res_valid_o, bus.res_data_o, bus.res_cmp_o); end
    checks++; if (bus.res_src_o !== 2'd1 || bus.res_tag_o !== 4'd2) begin errors++; $display("FAIL cont_res1_src got %0d tag %0d exp 1 tag 2", bus.res_src_o, bus.res_tag_o); end
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL cont_third got %b exp 01", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_src_o !== 2'd0 || bus.res_data_o !== 32'd300) begin errors++; $display("FAIL cont_res2 got v%b src %0d %0d exp v1 src 0 300", bus.res_valid_o, bus.res_src_o, bus.res_data_o); end
    @(negedge clk);
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 100, 32'hFFFF_FF38, ADD, 4);
    bus.req_valid_i = 2'b01;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL bp_grant got %b exp 01", bus.req_ready_o); end
    @(negedge clk);
    set_req(1, 1, 2, ADD, 5);
    bus.req_valid_i = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'hFFFF_FF9C || bus.res_tag_o !== 4'd4 || bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL bp_hold%0d got v%b %h tag %0d ready %b exp v1 ffffff9c tag 4 ready 00", c, bus.res_valid_o, bus.res_data_o, bus.res_tag_o, bus.req_ready_o); end
    end
    @(negedge clk);
    bus.res_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b10 || bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL bp_accept got ready %b valid %b exp 10 1", bus.req_ready_o, bus.res_valid_o); end
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    checks++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL bp_next_exec got valid %b busy %b exp 0 1", bus.res_valid_o, bus.busy_o); end
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== 32'd3 || bus.res_tag_o !== 4'd5 || bus.res_src_o !== 2'd1) begin errors++; $display("FAIL bp_next_res got v%b %0d tag %0d src %0d exp v1 3 tag 5 src 1", bus.res_valid_o, bus.res_data_o, bus.res_tag_o, bus.res_src_o); end
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL bp_idle got busy %b valid %b exp 0 0", bus.busy_o, bus.res_valid_o); end
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_fu_busy();
    do_reset();
    fu = 1'b0;
    set_req(0, 32'hFFFF_FE0C, 200, GE, 7);
    bus.req_valid_i = 2'b01;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL fu_grant got %b exp 01", bus.req_ready_o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_valid_i = 2'b00;
      checks++; if (bus.alu_op_A_o !== 32'hFFFF_FE0C || bus.alu_op_B_o !== 32'd200 || bus.alu_ops_o !== GE || bus.busy_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL fu_wait%0d got %h %0d op %0d busy %b valid %b exp fffffe0c 200 op 3 busy 1 valid 0", c, bus.alu_op_A_o, bus.alu_op_B_o, bus.alu_ops_o, bus.busy_o, bus.res_valid_o); end
    end
    fu = 1'b1;
    @(negedge clk);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_cmp_o !== 1'b0 || bus.res_tag_o !== 4'd7) begin errors++; $display("FAIL fu_result got v%b cmp %b tag %0d exp v1 cmp 0 tag 7", bus.res_valid_o, bus.res_cmp_o, bus.res_tag_o); end
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fu = 1'b0;
    set_req(0, 11, 22, SUB, 9);
    bus.req_valid_i = 2'b01;
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL rmid_ctrl got busy %b valid %b ready %b exp 0 0 00", bus.busy_o, bus.res_valid_o, bus.req_ready_o); end
    checks++; if ({bus.alu_op_A_o, bus.alu_op_B_o, bus.alu_ops_o} !== '0) begin errors++; $display("FAIL rmid_alu got %h %h %h exp 0", bus.alu_op_A_o, bus.alu_op_B_o, bus.alu_ops_o); end
    @(negedge clk);
    rst = 1'b0;
    fu = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d got valid %b busy %b exp 0 0", c, bus.res_valid_o, bus.busy_o); end
    end
    set_req(1, 3, 4, ADD, 2);
    bus.req_valid_i = 2'b11;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL rmid_ptr got %b exp 01", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    bus.res_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.req_ready_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL idle%0d got ready %b busy %b valid %b exp 00 0 0", c, bus.req_ready_o, bus.busy_o, bus.res_valid_o); end
    end
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.res_ready_i = 1'b0;
    bus.req_op_A_i = '0;
    bus.req_op_B_i = '0;
    bus.req_ops_i = '0;
    bus.req_tag_i = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fu_busy();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
